// File: rtl/fft8_pkg.sv
// Shared definitions for the fft8 streaming controller: FSM states, frame
// geometry and the default watchdog limit.
package fft8_pkg;

  typedef enum logic [2:0] {
    FILL    = 3'd0,
    WRITE   = 3'd1,
    WAIT    = 3'd2,
    CAPTURE = 3'd3,
    CRST    = 3'd4
  } fft8_state_e;

  localparam int FFT8_N           = 8;
  localparam int FFT8_TMO_CYC_DEF = 16;

  // One packed sample is {imag, real}; real sits in the low half.
  function automatic int fft8_stride(input int data_w);
    return 2 * data_w;
  endfunction

endpackage

// File: rtl/fft8_frame_buf.sv
// Eight-entry sample buffer: serial write by index or whole-frame parallel
// load, with the full frame always visible on the parallel output.
module fft8_frame_buf
  import fft8_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [2:0]              wr_idx,
  input  logic [2*DATA_W-1:0]     wr_data,
  input  logic                    ld_en,
  input  logic [8*2*DATA_W-1:0]   ld_frame,
  output logic [8*2*DATA_W-1:0]   frame
);

  localparam int SW = fft8_stride(DATA_W);

  logic [SW-1:0] mem_q [FFT8_N];
  logic [SW-1:0] mem_d [FFT8_N];

  // A parallel load wins over a serial write; the controller never issues both.
  always_comb begin
    for (int k = 0; k < FFT8_N; k++) begin
      mem_d[k] = mem_q[k];
      if (ld_en) begin
        mem_d[k] = ld_frame[k*SW +: SW];
      end else if (wr_en && (wr_idx == 3'(k))) begin
        mem_d[k] = wr_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < FFT8_N; k++) mem_q[k] <= '0;
    end else begin
      for (int k = 0; k < FFT8_N; k++) mem_q[k] <= mem_d[k];
    end
  end

  always_comb begin
    frame = '0;
    for (int k = 0; k < FFT8_N; k++) frame[k*SW +: SW] = mem_q[k];
  end

endmodule

// File: rtl/fft8_stream_ctrl.sv
// Streams 8 samples into an fft8 core and 8 bins back out, overlapping the next
// fill with the current drain. Watchdog on core completion: FFT8_CTRL_WATCHDOG_EN.
module fft8_stream_ctrl
  import fft8_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int TMO_CYC = FFT8_TMO_CYC_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_re,
  input  logic [DATA_W-1:0]     in_im,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_re,
  output logic [DATA_W-1:0]     out_im,
  output logic                  out_last,
  output logic                  core_rst_n,
  output logic                  core_write,
  output logic                  core_start,
  input  logic                  core_ready,
  output logic [8*2*DATA_W-1:0] core_x,
  input  logic [8*2*DATA_W-1:0] core_y,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  err,
  output fft8_state_e           dbg_state
);

  localparam int SW = fft8_stride(DATA_W);

  // Handshakes: a beat moves on the rising edge where valid && ready are both
  // high; valid never waits on ready, and data is held until the beat moves.
  fft8_state_e state_q, state_d;
  logic [2:0] in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
  logic out_full_q, out_full_d;
  logic in_ready_q, core_write_q, core_start_q, core_rst_n_q, busy_q, frame_done_q;
  logic in_fire, out_fire, cap_load, wd_tmo;
  logic [8*2*DATA_W-1:0] out_frame;

  assign in_fire  = in_valid && in_ready_q;
  assign out_fire = out_full_q && out_ready;

`ifdef FFT8_CTRL_WATCHDOG_EN
  localparam int WD_W = $clog2(TMO_CYC + 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic err_q, err_d;

  always_comb begin
    wd_d   = (state_q == WAIT) ? wd_q + 1'b1 : '0;
    wd_tmo = (state_q == WAIT) && !core_ready && (wd_q == WD_W'(TMO_CYC - 1));
    err_d  = err_q | wd_tmo;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign wd_tmo = 1'b0;
  assign err    = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    in_cnt_d   = in_cnt_q;
    out_cnt_d  = out_cnt_q;
    out_full_d = out_full_q;
    cap_load   = 1'b0;
    if (in_fire) in_cnt_d = in_cnt_q + 3'd1;
    if (out_fire) begin
      out_cnt_d = out_cnt_q + 3'd1;
      if (out_cnt_q == 3'd7) out_full_d = 1'b0;
    end
    case (state_q)
      FILL:    if (in_fire && (in_cnt_q == 3'd7)) state_d = WRITE;
      WRITE:   state_d = WAIT;
      WAIT: begin
        if (core_ready)  state_d = CAPTURE;
        else if (wd_tmo) state_d = CRST;
      end
      // Load only into an empty output buffer; a full one stalls the core frame here.
      CAPTURE: if (!out_full_q) begin
        cap_load   = 1'b1;
        out_full_d = 1'b1;
        state_d    = CRST;
      end
      CRST:    state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= FILL;
      in_cnt_q     <= 3'd0;
      out_cnt_q    <= 3'd0;
      out_full_q   <= 1'b0;
      in_ready_q   <= 1'b0;
      core_write_q <= 1'b0;
      core_start_q <= 1'b0;
      core_rst_n_q <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      in_cnt_q     <= in_cnt_d;
      out_cnt_q    <= out_cnt_d;
      out_full_q   <= out_full_d;
      in_ready_q   <= (state_d == FILL);
      core_write_q <= (state_d == WRITE);
      core_start_q <= (state_d == WAIT);
      core_rst_n_q <= (state_d != CRST);
      busy_q       <= (state_d != FILL);
      frame_done_q <= cap_load;
    end
  end

  fft8_frame_buf #(.DATA_W(DATA_W)) u_in_buf (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (in_fire),
    .wr_idx   (in_cnt_q),
    .wr_data  ({in_im, in_re}),
    .ld_en    (1'b0),
    .ld_frame ('0),
    .frame    (core_x)
  );

  fft8_frame_buf #(.DATA_W(DATA_W)) u_out_buf (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (1'b0),
    .wr_idx   (3'd0),
    .wr_data  ('0),
    .ld_en    (cap_load),
    .ld_frame (core_y),
    .frame    (out_frame)
  );

  assign in_ready   = in_ready_q;
  assign core_write = core_write_q;
  assign core_start = core_start_q;
  assign core_rst_n = core_rst_n_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign out_valid  = out_full_q;
  assign out_last   = out_full_q && (out_cnt_q == 3'd7);
  assign out_re     = out_frame[out_cnt_q*SW +: DATA_W];
  assign out_im     = out_frame[out_cnt_q*SW + DATA_W +: DATA_W];
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_fft8_stream_ctrl.sv
// Directed bench for fft8_stream_ctrl with a behavioural fft8 core (4-cycle
// latency) and a scoreboard queue of expected output bins.
module tb_fft8_stream_ctrl;
  import fft8_pkg::*;

  localparam int W  = 16;
  localparam int FW = 8 * 2 * W;
  localparam int WR[8] = '{256, 181, 0, -181, -256, -181, 0, 181};
  localparam int WI[8] = '{0, -181, -256, -181, 0, 181, 256, 181};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, in_ready;
  logic [W-1:0] in_re = '0, in_im = '0;
  logic out_valid, out_ready = 1'b0, out_last;
  logic [W-1:0] out_re, out_im;
  logic core_rst_n, core_write, core_start;
  logic core_ready = 1'b0;
  logic [FW-1:0] core_x;
  logic [FW-1:0] core_y = '0;
  logic busy, frame_done, err;
  fft8_state_e dbg_state;

  int n_checks = 0, n_fail = 0;
  logic [2*W-1:0] exp_q[$];
  int beat_cnt = 0, beats_total = 0, fd_cnt = 0, stall_cnt = 0, crst_cnt = 0;
  int rdy_mode = 0, cyc = 0, core_cnt = 0;
  logic core_hang = 1'b0;

  fft8_stream_ctrl #(.DATA_W(W), .TMO_CYC(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
    .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
    .out_last(out_last),
    .core_rst_n(core_rst_n), .core_write(core_write), .core_start(core_start),
    .core_ready(core_ready), .core_x(core_x), .core_y(core_y),
    .busy(busy), .frame_done(frame_done), .err(err), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference fft8 (Q8 twiddles) ----------------
  function automatic logic [FW-1:0] dft8(input logic [FW-1:0] x);
    logic [FW-1:0] y;
    y = '0;
    for (int k = 0; k < 8; k++) begin
      int ar, ai;
      ar = 0;
      ai = 0;
      for (int n = 0; n < 8; n++) begin
        int xr, xi, m;
        m  = (k * n) % 8;
        xr = int'($signed(x[n*32 +: 16]));
        xi = int'($signed(x[n*32+16 +: 16]));
        ar += xr * WR[m] - xi * WI[m];
        ai += xr * WI[m] + xi * WR[m];
      end
      y[k*32 +: 16]    = 16'(ar >>> 8);
      y[k*32+16 +: 16] = 16'(ai >>> 8);
    end
    return y;
  endfunction

  function automatic logic [FW-1:0] rand_frame();
    logic [FW-1:0] x;
    for (int n = 0; n < 16; n++) x[n*16 +: 16] = 16'($urandom_range(0, 1023)) - 16'd512;
    return x;
  endfunction

  // Core model: ready 4 cycles after the write cycle, cleared by sync core reset.
  always @(posedge clk) begin
    if (!core_rst_n) begin
      core_ready <= 1'b0;
      core_cnt   <= 0;
    end else if (core_write) begin
      core_y   <= dft8(core_x);
      core_cnt <= 1;
    end else if (core_cnt == 3 && !core_hang) begin
      core_ready <= 1'b1;
      core_cnt   <= 0;
    end else if (core_cnt != 0) begin
      core_cnt <= core_cnt + 1;
    end
  end

  // ---------------- check helper ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // ---------------- output side: ready pattern + scoreboard ----------------
  always @(negedge clk) begin
    logic [2*W-1:0] e;
    cyc++;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = cyc[0];
      default: out_ready = 1'b0;
    endcase
    if (!rst) begin
      beat_cnt = 0;
    end else begin
      if (frame_done) fd_cnt++;
      if (dbg_state == CAPTURE && out_valid) stall_cnt++;
      if (!core_rst_n) crst_cnt++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("out_extra_beat", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check("out_data", {out_im, out_re}, e);
          check("out_last", out_last, (beat_cnt == 7));
        end
        beat_cnt = (beat_cnt + 1) % 8;
        beats_total++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_sample(input logic [W-1:0] re, input logic [W-1:0] im);
    int t;
    t = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_re    = re;
    in_im    = im;
    while (!in_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("in_ready_wait", in_ready, 1);
  endtask

  task automatic send_frame(input logic [FW-1:0] x, input logic [FW-1:0] exp_y, input bit push);
    for (int n = 0; n < 8; n++) send_sample(x[n*32 +: 16], x[n*32+16 +: 16]);
    if (push) for (int k = 0; k < 8; k++) exp_q.push_back(exp_y[k*32 +: 32]);
  endtask

  task automatic end_input();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(negedge clk);
      #2;
      t++;
    end
    check(tag, exp_q.size(), 0);
  endtask

  // Asserts reset at the current time, checks the reset values, releases on a
  // falling edge and checks the first cycle after release.
  task automatic do_reset();
    rst      = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_core_write", core_write, 0);
    check("rst_core_start", core_start, 0);
    check("rst_core_rst_n", core_rst_n, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_err", err, 0);
    check("rst_state", 32'(dbg_state), 32'(FILL));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rel_in_ready", in_ready, 1);
    check("rel_core_rst_n", core_rst_n, 1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [FW-1:0] x, y;
    int t, fd0, st0, bt0, cr0;

    @(negedge clk);
    do_reset();

    // Impulse: every bin equals x0.
    rdy_mode = 0;
    fd0 = fd_cnt;
    x = '0;
    x[15:0] = 16'h0100;
    for (int k = 0; k < 8; k++) y[k*32 +: 32] = 32'h0000_0100;
    send_frame(x, y, 1'b1);
    end_input();
    wait_drain("impulse_drain");
    check("impulse_frame_done", fd_cnt - fd0, 1);

    // DC: all energy in bin 0.
    x = '0;
    y = '0;
    for (int n = 0; n < 8; n++) x[n*32 +: 16] = 16'h0100;
    y[31:0] = 32'h0000_0800;
    send_frame(x, y, 1'b1);
    end_input();
    wait_drain("dc_drain");

    // Three back-to-back frames against a toggling out_ready.
    rdy_mode = 1;
    fd0 = fd_cnt;
    st0 = stall_cnt;
    bt0 = beats_total;
    for (int f = 0; f < 3; f++) begin
      x = rand_frame();
      send_frame(x, dft8(x), 1'b1);
    end
    end_input();
    wait_drain("bp_drain");
    check("bp_beats", beats_total - bt0, 24);
    check("bp_frame_done", fd_cnt - fd0, 3);
    check("bp_stall_seen", (stall_cnt - st0) > 0, 1);

    // Reset after the 5th input sample, then a clean frame.
    rdy_mode = 0;
    x = rand_frame();
    for (int n = 0; n < 5; n++) send_sample(x[n*32 +: 16], x[n*32+16 +: 16]);
    @(negedge clk);
    do_reset();
    x = rand_frame();
    send_frame(x, dft8(x), 1'b1);
    end_input();
    wait_drain("post_rst_in_drain");

    // Reset during drain beat 3, then a clean frame.
    x = rand_frame();
    send_frame(x, dft8(x), 1'b1);
    end_input();
    t = 0;
    while (beat_cnt != 3 && t < 500) begin
      @(negedge clk);
      #2;
      t++;
    end
    check("drain_beat3_reached", beat_cnt, 3);
    do_reset();
    x = rand_frame();
    send_frame(x, dft8(x), 1'b1);
    end_input();
    wait_drain("post_rst_out_drain");

    // Core that never completes.
    core_hang = 1'b1;
    bt0 = beats_total;
    cr0 = crst_cnt;
    x = rand_frame();
    send_frame(x, dft8(x), 1'b0);
    end_input();
`ifdef FFT8_CTRL_WATCHDOG_EN
    t = 0;
    while (!core_start && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("wd_wait_entered", core_start, 1);
    t = 0;
    while (!err && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("wd_err_latency", t, 16);
    repeat (4) @(negedge clk);
    check("wd_crst_pulses", crst_cnt - cr0, 1);
    check("wd_state_fill", 32'(dbg_state), 32'(FILL));
    check("wd_err_sticky", err, 1);
    check("wd_no_output", beats_total - bt0, 0);
`else
    repeat (40) @(negedge clk);
    check("hang_state_wait", 32'(dbg_state), 32'(WAIT));
    check("hang_core_start", core_start, 1);
    check("hang_busy", busy, 1);
    check("hang_err", err, 0);
    check("hang_no_crst", crst_cnt - cr0, 0);
    check("hang_no_output", beats_total - bt0, 0);
`endif
    core_hang = 1'b0;
    @(negedge clk);
    do_reset();
    x = rand_frame();
    send_frame(x, dft8(x), 1'b1);
    end_input();
    wait_drain("recover_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fft8_stream_ctrl.md
FFT8_STREAM_CTRL -- requirements
Module: fft8_stream_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, giving the width of each real/imag sample component (Q8.8 two's complement).
REQ-002 The block SHALL have parameter TMO_CYC, default 16, giving the watchdog limit in cycles for core completion.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 in_valid in 1, in_ready out 1, in_re in DATA_W, in_im in DATA_W: input sample stream, natural order x0..x7.
REQ-006 out_valid out 1, out_ready in 1, out_re out DATA_W, out_im out DATA_W, out_last out 1: output bin stream y0..y7, with out_last set on y7.
REQ-007 core_rst_n out 1, core_write out 1, core_start out 1, core_ready in 1: control signals to the fft8 core (core reset is synchronous, low).
REQ-008 core_x out 8*2*DATA_W, core_y in 8*2*DATA_W: packed frame; sample k real at [32k+15:32k], imag at [32k+31:32k+16].
REQ-009 busy out 1 (core frame in flight), frame_done out 1 (one-cycle pulse per captured frame), err out 1 (sticky watchdog error).

Function
REQ-010 Input side: a sample SHALL transfer on in_valid&&in_ready; in_cnt (0..7) SHALL index the in_buf slot and wrap 7->0.
REQ-011 in_ready SHALL be 1 only in FILL; the 8th transfer SHALL move the FSM FILL->WRITE.
REQ-012 core_x SHALL be driven from in_buf and SHALL stay stable from WRITE until the FSM leaves WAIT.
REQ-013 FSM states SHALL be FILL, WRITE, WAIT, CAPTURE, CRST.
REQ-014 FILL->WRITE SHALL occur after the 8th input transfer.
REQ-015 WRITE SHALL last one cycle with core_write=1, then go to WAIT.
REQ-016 In WAIT, core_start SHALL be 1; on core_ready=1 the FSM SHALL go to CAPTURE.
REQ-017 CAPTURE SHALL wait while the output buffer is occupied; when it is empty the block SHALL load out_buf<=core_y, pulse frame_done, and go to CRST.
REQ-018 CRST SHALL drive core_rst_n=0 for exactly one cycle, then go to FILL; in all other states core_rst_n SHALL be 1.
REQ-019 Core latency from the core_write cycle to core_ready high SHALL be 4 cycles; the controller SHALL NOT depend on this value (it waits on core_ready).
REQ-020 busy SHALL be 1 in WRITE, WAIT, CAPTURE and CRST.
REQ-021 Output side: while the output buffer is occupied, out_valid SHALL be 1 and out_re/out_im SHALL equal out_buf[out_cnt].
REQ-022 out_cnt SHALL advance on out_valid&&out_ready; the transfer at out_cnt=7 SHALL assert out_last, free the buffer, and wrap out_cnt to 0.
REQ-023 Filling of frame N+1 SHALL overlap draining of frame N; if draining is incomplete when the core finishes, the block SHALL stall in CAPTURE.
REQ-024 If the buffer is freed and CAPTURE loads in the same cycle, the new frame SHALL be presented on the next cycle with no bubble beyond that one cycle.
REQ-025 The block SHALL perform no arithmetic on data; samples SHALL pass bit-exact.

Reset
REQ-026 On rst low (asynchronous, any state, including mid-frame), the FSM SHALL go to FILL and in_cnt, out_cnt and the wd counter SHALL clear to 0.
REQ-027 On rst low, in_ready=0 during reset, out_valid=0, out_last=0, core_write=0, core_start=0, core_rst_n=0, busy=0, frame_done=0, err=0, and the output buffer SHALL be empty.
REQ-028 On the first cycle after release, core_rst_n SHALL be 1 and in_ready SHALL be 1.
REQ-029 Any partial input or output frame SHALL be discarded on reset.

Configuration
REQ-030 With FFT8_CTRL_WATCHDOG_EN defined, the wd counter SHALL count WAIT cycles; reaching TMO_CYC without core_ready SHALL set err (sticky until rst), discard the frame (no capture), and go to CRST.
REQ-031 Without FFT8_CTRL_WATCHDOG_EN, WAIT SHALL be held indefinitely, err SHALL be tied 0, and no counter logic SHALL be present.

Structure
REQ-032 Shared package fft8_pkg SHALL hold the FSM state enum, the packed-frame slice helper constants (sample stride 2*DATA_W), and the default TMO_CYC.
REQ-033 One sub-module SHALL be natural: fft8_frame_buf, an 8-entry serial-in/parallel-out buffer (also used parallel-in/serial-out for the output side).

Verification
REQ-034 Impulse: x0=0x0100, all other inputs 0 (real core) -> all 8 outputs re=0x0100, im=0x0000; out_last only on the 8th beat.
REQ-035 DC: all 8 inputs re=0x0100 -> y0 re=0x0800, y1..y7 = 0.
REQ-036 Backpressure: out_ready toggles 1/0 while 3 frames are streamed back-to-back -> no loss or duplication, CAPTURE stall observed, and frame order preserved.
REQ-037 Watchdog (macro on): core_ready tied 0 -> err=1 exactly TMO_CYC=16 cycles after entering WAIT, one core_rst_n low pulse, FILL re-entered, and no output emitted.
REQ-038 Reset mid-operation: assert rst after the 5th input sample and again during drain beat 3 -> outputs go to reset values immediately, and the next full frame is processed correctly.
